arbitri_mux2ne1: RTL

ARBITRI_MUX2NE1 -- requirements
Module: arbitri_mux2ne1

---
 rtl/arbitri_mux2ne1_pkg.sv | 17 +
 rtl/arbitri_mux2ne1_mux.sv | 11 +
 rtl/arbitri_mux2ne1.sv | 127 ++++++++++++
 3 files changed

// File: rtl/arbitri_mux2ne1_pkg.sv
// Shared definitions for the two-source burst arbiter: state encodings,
// source identifiers and the default burst length.
package arbitri_mux2ne1_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRONAR1 = 2'd1,
    PRONAR2 = 2'd2
  } state_e;

  localparam int unsigned MAX_BURST_DEF = 4;

  // Priority pointer values: which source wins when both request from IDLE.
  localparam logic SRC1 = 1'b0;
  localparam logic SRC2 = 1'b1;

endpackage

// File: rtl/arbitri_mux2ne1_mux.sv
// Four-bit two-to-one data multiplexer; sel = 0 passes a, sel = 1 passes b.
module Mux2ne1_4Bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       sel,
  output logic [3:0] y
);

  assign y = sel ? b : a;

endmodule

// File: rtl/arbitri_mux2ne1.sv
// Two-source arbiter with bounded bursts: one owner streams into a registered
// output stage until it stops, or until its burst limit is reached while the other source waits.
module arbitri_mux2ne1
  import arbitri_mux2ne1_pkg::*;
#(
  parameter int unsigned MAX_BURST = MAX_BURST_DEF
) (
  input  logic       Clock,
  input  logic       Reset_n,
  input  logic [3:0] Hyrja1,
  input  logic       Valid1,
  output logic       Gati1,
  input  logic [3:0] Hyrja2,
  input  logic       Valid2,
  output logic       Gati2,
  output logic [3:0] Dalja,
  output logic       ValidD,
  input  logic       GatiD,
  output logic       S
);

  localparam logic [3:0] BURST_LIMIT = 4'(MAX_BURST);

  state_e     state_q, state_d;
  logic       p_q, p_d;
  logic [3:0] cnt_q, cnt_d;
  logic       s_q, s_d;
  logic       validd_q, validd_d;
  logic [3:0] dalja_q, dalja_d;

  logic       out_free;
  logic       gati1, gati2;
  logic       xfer;
  logic       own_valid, other_valid;
  state_e     other_state;
  logic [3:0] cnt_inc;
  logic [3:0] mux_y;

  Mux2ne1_4Bit u_mux (
    .a  (Hyrja1),
    .b  (Hyrja2),
    .sel(s_q),
    .y  (mux_y)
  );

  always_comb begin
    out_free    = !validd_q || GatiD;
    gati1       = (state_q == PRONAR1) && out_free;
    gati2       = (state_q == PRONAR2) && out_free;
    xfer        = (Valid1 && gati1) || (Valid2 && gati2);
    own_valid   = (state_q == PRONAR2) ? Valid2 : Valid1;
    other_valid = (state_q == PRONAR2) ? Valid1 : Valid2;
    other_state = (state_q == PRONAR2) ? PRONAR1 : PRONAR2;
    cnt_inc     = cnt_q + 4'd1;

    state_d  = state_q;
    p_d      = p_q;
    cnt_d    = cnt_q;
    s_d      = s_q;
    validd_d = validd_q;
    dalja_d  = dalja_q;

    if (xfer) begin
      dalja_d  = mux_y;
      validd_d = 1'b1;
    end else if (validd_q && GatiD) begin
      validd_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (Valid1 && (!Valid2 || p_q == SRC1)) state_d = PRONAR1;
        else if (Valid2)                        state_d = PRONAR2;
      end
      PRONAR1, PRONAR2: begin
        if (!own_valid) begin
          state_d = other_valid ? other_state : IDLE;
        end else if (xfer) begin
          // A full burst hands over only if the other source is waiting.
          if (cnt_inc == BURST_LIMIT) begin
            if (other_valid) state_d = other_state;
            else             cnt_d   = 4'd0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d != state_q) begin
      cnt_d = 4'd0;
      if (state_d == PRONAR1) begin
        p_d = SRC2;
        s_d = 1'b0;
      end else if (state_d == PRONAR2) begin
        p_d = SRC1;
        s_d = 1'b1;
      end
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= IDLE;
      p_q      <= SRC1;
      cnt_q    <= 4'd0;
      s_q      <= 1'b0;
      validd_q <= 1'b0;
      dalja_q  <= 4'h0;
    end else begin
      state_q  <= state_d;
      p_q      <= p_d;
      cnt_q    <= cnt_d;
      s_q      <= s_d;
      validd_q <= validd_d;
      dalja_q  <= dalja_d;
    end
  end

  assign Gati1  = gati1;
  assign Gati2  = gati2;
  assign Dalja  = dalja_q;
  assign ValidD = validd_q;
  assign S      = s_q;

endmodule
